// File: rtl/exe_mem_stage_buf.sv
// rtl/exe_mem_stage_buf.sv - EXE/MEM two-entry elastic pipeline buffer
// Main entry drives MEM; skid entry absorbs one instruction under back-pressure.
module exe_mem_stage_buf #(
  parameter int WORD_LEN     = 16,
  parameter int REG_ADDR_LEN = 3,
  parameter int INSTR_LEN    = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    wb_en_in,
  input  logic                    mem_r_en_in,
  input  logic                    mem_w_en_in,
  input  logic [WORD_LEN-1:0]     pc_in,
  input  logic [WORD_LEN-1:0]     alu_res_in,
  input  logic [WORD_LEN-1:0]     st_val_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic [REG_ADDR_LEN-1:0] custom_dest_in,
  input  logic [INSTR_LEN-1:0]    instr_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    wb_en,
  output logic                    mem_r_en,
  output logic                    mem_w_en,
  output logic [WORD_LEN-1:0]     pc,
  output logic [WORD_LEN-1:0]     alu_res,
  output logic [WORD_LEN-1:0]     st_val,
  output logic [REG_ADDR_LEN-1:0] dest,
  output logic [REG_ADDR_LEN-1:0] custom_dest,
  output logic [INSTR_LEN-1:0]    instr,
  output logic                    fwd_valid,
  output logic [CNT_W-1:0]        stall_cycles
);

  localparam int ENTRY_W = 3 + 3 * WORD_LEN + 2 * REG_ADDR_LEN + INSTR_LEN;

  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [ENTRY_W-1:0] entry_in;
  logic               accept;
  logic               consume;

  assign entry_in = {wb_en_in, mem_r_en_in, mem_w_en_in, pc_in, alu_res_in,
                     st_val_in, dest_in, custom_dest_in, instr_in};

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign consume   = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q) begin
      if (accept) begin
        main_d       = entry_in;
        main_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (accept && consume) begin
        main_d = entry_in;
      end else if (accept) begin
        skid_d       = entry_in;
        skid_valid_d = 1'b1;
      end else if (consume) begin
        main_valid_d = 1'b0;
      end
    end else if (consume) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end
    // Squash drops entries but leaves payload untouched so outputs hold stale data.
    if (flush) begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  assign {wb_en, mem_r_en, mem_w_en} = main_q[ENTRY_W-1 -: 3] & {3{main_valid_q}};
  assign {pc, alu_res, st_val, dest, custom_dest, instr} = main_q[ENTRY_W-4:0];
  assign fwd_valid    = wb_en;
  assign stall_cycles = stall_q;

endmodule
